// File: rtl/intesn_readout.sv
// Linear readout for the intESN reservoir: streams one snapshot of neuron states,
// multiply-accumulates against a programmable signed weight vector, emits one scalar.
module intesn_readout #(
  parameter int unsigned reservoir_size = 4,
  parameter int unsigned data_width     = 3,
  parameter int unsigned weight_size    = 16,
  parameter int unsigned ADDR_W         = $clog2(reservoir_size),
  parameter int unsigned ACC_W          = data_width + weight_size + ADDR_W + 1
) (
  input  logic                           iClk,
  input  logic                           iRst_n,
  input  logic                           iEn,
  input  logic                           iStart,
  input  logic signed [data_width-1:0]   iState,
  input  logic                           iStateValid,
  output logic                           oStateReady,
  input  logic                           iWe,
  input  logic        [ADDR_W-1:0]       iWAddr,
  input  logic signed [weight_size-1:0]  iWData,
  output logic signed [ACC_W-1:0]        oValue,
  output logic                           oValid,
  output logic                           oBusy
);

  typedef enum logic {StIdle, StAccum} state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(reservoir_size - 1);

  state_e                          stateQ, stateD;
  logic        [ADDR_W-1:0]        idxQ, idxD;
  logic signed [ACC_W-1:0]         accQ, accD;
  logic signed [ACC_W-1:0]         valueD;
  logic                            validD;
  logic                            wrEn;
  logic signed [weight_size-1:0]   weights [reservoir_size];

  logic signed [ACC_W-1:0]         stateExt, weightExt, prod, accSum;

  // Both operands are widened before the multiply so the product never wraps.
  assign stateExt  = ACC_W'(iState);
  assign weightExt = ACC_W'(weights[idxQ]);
  assign prod      = stateExt * weightExt;
  assign accSum    = accQ + prod;

  assign oBusy = (stateQ == StAccum);

  always_comb begin
    stateD      = stateQ;
    idxD        = idxQ;
    accD        = accQ;
    valueD      = oValue;
    validD      = 1'b0;
    wrEn        = 1'b0;
    oStateReady = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (iEn) begin
          wrEn = iWe;
          if (iStart) begin
            accD   = '0;
            idxD   = '0;
            stateD = StAccum;
          end
        end
      end
      StAccum: begin
        oStateReady = iEn;
        if (iEn && iStateValid) begin
          if (idxQ == LastIdx) begin
            valueD = accSum;
            validD = 1'b1;
            accD   = '0;
            idxD   = '0;
            stateD = StIdle;
          end else begin
            accD = accSum;
            idxD = idxQ + ADDR_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateQ <= StIdle;
      idxQ   <= '0;
      accQ   <= '0;
      oValue <= '0;
      oValid <= 1'b0;
    end else begin
      stateQ <= stateD;
      idxQ   <= idxD;
      accQ   <= accD;
      oValue <= valueD;
      oValid <= validD;
    end
  end

  // Out-of-range addresses match no entry and are dropped.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int unsigned i = 0; i < reservoir_size; i++) begin
        weights[i] <= '0;
      end
    end else if (wrEn) begin
      for (int unsigned i = 0; i < reservoir_size; i++) begin
        if (iWAddr == ADDR_W'(i)) begin
          weights[i] <= iWData;
        end
      end
    end
  end

endmodule

// File: doc/intesn_readout.md
Name: intesn_readout

Overview:
- Linear readout stage downstream of the intESN reservoir.
- Consumes one snapshot of reservoir state (reservoir_size clipped integer neurons), streamed one element per handshake.
- Multiply-accumulates each element against a programmable signed weight vector and emits one signed scalar per snapshot with a valid pulse.
- Weights are loaded through a simple write port while the block is idle.

Parameters:
- reservoir_size, 4, number of neurons per snapshot; must be ≥2.
- data_width, 3, width of a reservoir element, signed two's complement.
- weight_size, 16, width of a readout weight, signed two's complement.
- ADDR_W, $clog2(reservoir_size), weight address and element index width.
- ACC_W, data_width+weight_size+ADDR_W+1, accumulator and output width, signed; 22 at defaults.

Ports:
- iClk  in  1  clock, rising edge
- iRst_n  in  1  asynchronous active-low reset
- iEn  in  1  global enable; when low, all state holds and no handshake occurs
- iStart  in  1  begin readout of a new snapshot; sampled only in IDLE
- iState  in  data_width  reservoir element, signed
- iStateValid  in  1  iState is valid
- oStateReady  out  1  block accepts iState this cycle
- iWe  in  1  weight write strobe
- iWAddr  in  ADDR_W  weight index
- iWData  in  weight_size  weight value, signed
- oValue  out  ACC_W  readout result, signed, registered
- oValid  out  1  one-cycle pulse; oValue is new
- oBusy  out  1  high when not in IDLE

Behaviour:
- Reset, asynchronous on iRst_n=0: state=IDLE, idx=0, acc=0, all weights=0, oValue=0, oValid=0, oStateReady=0, oBusy=0.
- FSM has two states: IDLE and ACCUM. oValid defaults to 0 every cycle unless set below.
- IDLE:
  - oStateReady=0.
  - If iEn=1 and iWe=1, w[iWAddr] <= iWData. Addresses ≥ reservoir_size are ignored.
  - If iEn=1 and iStart=1: acc<=0, idx<=0, next state ACCUM.
  - If iWe and iStart occur in the same cycle, the write takes effect and is used by the snapshot just started.
- ACCUM:
  - oStateReady = iEn.
  - Handshake is iEn & iStateValid & oStateReady.
  - On a handshake: p = sext(iState) * sext(w[idx]), computed in ACC_W bits.
  - If idx < reservoir_size-1: acc <= acc+p, idx <= idx+1.
  - If idx == reservoir_size-1: oValue <= acc+p, oValid <= 1, acc <= 0, idx <= 0, state <= IDLE.
  - No handshake (iStateValid=0 or iEn=0): hold everything.
  - iStart is ignored. iWe is ignored (weights frozen).
- Latency: oValid is high in the cycle immediately after the last element's handshake. A back-to-back snapshot needs one IDLE cycle with iStart, so the minimum period is reservoir_size+1 cycles.
- oValue holds its value until the next oValid. oBusy=1 throughout ACCUM.
- Arithmetic: ACC_W guarantees no overflow. Worst case is reservoir_size*(-2^(data_width-1))*(-2^(weight_size-1)). No saturation or truncation.
- iEn=0 freezes the FSM, index, accumulator and weights, and forces oStateReady=0. oValid is still cleared to 0.
- Reset mid-snapshot discards partial acc. The next snapshot requires a fresh iStart and reloaded weights.

Test Plan:
- Basic dot product: load w=[1,-2,3,-4]; pulse iStart; stream iState=[3,-4,2,-1] with valid every cycle. Required: oValid pulse exactly 1 cycle after the 4th handshake, oValue=21, oBusy high for 4 cycles, then IDLE.
- Extremes: all w=-32768, all iState=-4. Required: oValue=+524288. Then all w=32767, iState=-4. Required: oValue=-524272. Checks sign extension and no wrap.
- Backpressure/stall: same data as the basic test, with iStateValid low for 2 cycles between elements 2 and 3 and iEn low for 3 cycles mid-stream. Required: oValue=21, no extra handshakes, oStateReady=0 while iEn=0.
- Ignored controls: during ACCUM, pulse iStart and write w[0]=100. Required: result unchanged (21). A subsequent snapshot with all iState=1 gives -2, proving the write was dropped.
- Simultaneous write+start: in IDLE, assert iWe (addr 0, data 5) together with iStart; stream [1,0,0,0]. Required: oValue=5.
- Reset mid-op: deassert iRst_n after 2 handshakes. Required: immediate oBusy=0, oValue=0, oValid=0, oStateReady=0. After release, reload the basic weights and rerun the basic stream. Required: oValue=21.
